preemption_timer: RTL

//   Time-slice watchdog that sits beside the control unit and consumes its status outputs.
//   It counts executed user-mode cycles and raises `interruption` when the OS quantum expires.
//   The control unit uses `interruption` to trap back into the OS.

---
 rtl/preemption_timer.sv | 118 +++++++++++
 1 files changed

// File: rtl/preemption_timer.sv
// Time-slice watchdog: counts user-mode pipeline advances and raises a registered
// preemption request when the OS quantum expires. Counting freezes during I/O.
module preemption_timer #(
    parameter int unsigned COUNTER_WIDTH   = 16,
    parameter int unsigned DEFAULT_QUANTUM = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     is_privileged,
    input  logic                     is_io,
    input  logic                     load_quantum,
    input  logic [COUNTER_WIDTH-1:0] quantum_value,
    input  logic                     interrupt_ack,
    output logic                     interruption,
    output logic [COUNTER_WIDTH-1:0] elapsed,
    output logic                     running
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] QUANTUM_RST = COUNTER_WIDTH'(DEFAULT_QUANTUM);
    localparam logic [COUNTER_WIDTH-1:0] ONE         = COUNTER_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] elapsed_q, elapsed_d;
    logic [COUNTER_WIDTH-1:0] quantum_q, quantum_d;
    logic                     interruption_q, interruption_d;
    logic                     running_q, running_d;
    logic [COUNTER_WIDTH-1:0] elapsed_inc;

    // elapsed never exceeds the quantum, so this increment cannot wrap
    assign elapsed_inc = elapsed_q + ONE;

    // Loads are only accepted in privileged mode, which always leaves RUN, so a
    // running slice never sees its quantum change underneath it.
    always_comb begin
        quantum_d = quantum_q;
        if (load_quantum && is_privileged) begin
            quantum_d = quantum_value;
        end
    end

    always_comb begin
        state_d        = state_q;
        elapsed_d      = elapsed_q;
        interruption_d = interruption_q;

        case (state_q)
            IDLE: begin
                elapsed_d      = '0;
                interruption_d = 1'b0;
                if (!is_privileged) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (is_privileged) begin
                    state_d   = IDLE;
                    elapsed_d = '0;
                end else if (quantum_q == '0) begin
                    elapsed_d = elapsed_q;
                end else if (enable && !is_io) begin
                    if (elapsed_inc == quantum_q) begin
                        state_d        = EXPIRED;
                        interruption_d = 1'b1;
                        elapsed_d      = quantum_q;
                    end else begin
                        elapsed_d = elapsed_inc;
                    end
                end
            end

            EXPIRED: begin
                interruption_d = 1'b1;
                if (interrupt_ack || is_privileged) begin
                    state_d        = IDLE;
                    interruption_d = 1'b0;
                    elapsed_d      = '0;
                end
            end

            default: begin
                state_d        = IDLE;
                elapsed_d      = '0;
                interruption_d = 1'b0;
            end
        endcase

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            elapsed_q      <= '0;
            quantum_q      <= QUANTUM_RST;
            interruption_q <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            elapsed_q      <= elapsed_d;
            quantum_q      <= quantum_d;
            interruption_q <= interruption_d;
            running_q      <= running_d;
        end
    end

    assign interruption = interruption_q;
    assign elapsed      = elapsed_q;
    assign running      = running_q;

endmodule
